// File: rtl/shared_dmem_arbiter.sv
// Two-core data-memory responder: round-robin arbitration onto one word array, registered read data.
// Optional access/conflict counters are enabled with `define SHARED_DMEM_STATS_EN.
module shared_dmem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr_i_1,
    input  logic [DATA_W-1:0] data_i_1,
    input  logic              MemRead_i_1,
    input  logic              MemWrite_i_1,
    output logic [DATA_W-1:0] data_o_1,
    output logic              rvalid_o_1,
    output logic              stall_o_1,
    input  logic [ADDR_W-1:0] addr_i_2,
    input  logic [DATA_W-1:0] data_i_2,
    input  logic              MemRead_i_2,
    input  logic              MemWrite_i_2,
    output logic [DATA_W-1:0] data_o_2,
    output logic              rvalid_o_2,
    output logic              stall_o_2
`ifdef SHARED_DMEM_STATS_EN
    ,
    output logic [15:0]       acc_cnt_o_1,
    output logic [15:0]       acc_cnt_o_2,
    output logic [15:0]       conflict_cnt_o
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    // Saturating 16-bit increment used by the statistics counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
        logic [15:0] res;
        if (en && (cnt != 16'hFFFF)) begin
            res = cnt + 16'd1;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    logic [IDX_W-1:0]  idx_1_s;
    logic [IDX_W-1:0]  idx_2_s;
    logic              req_1_s;
    logic              req_2_s;
    logic              gnt_1_s;
    logic              gnt_2_s;
    logic              contested_s;
    logic              rd_1_s;
    logic              rd_2_s;
    logic              wr_en_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic [DATA_W-1:0] wr_data_s;
    logic              unused_addr_s;

    logic              prio_q;
    logic              prio_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] data_o_1_q;
    logic [DATA_W-1:0] data_o_1_d;
    logic [DATA_W-1:0] data_o_2_q;
    logic [DATA_W-1:0] data_o_2_d;
    logic              rvalid_o_1_q;
    logic              rvalid_o_1_d;
    logic              rvalid_o_2_q;
    logic              rvalid_o_2_d;

    assign idx_1_s = addr_i_1[IDX_W+1:2];
    assign idx_2_s = addr_i_2[IDX_W+1:2];
    assign req_1_s = MemRead_i_1 | MemWrite_i_1;
    assign req_2_s = MemRead_i_2 | MemWrite_i_2;
    assign unused_addr_s = ^{addr_i_1[ADDR_W-1:IDX_W+2], addr_i_1[1:0],
                             addr_i_2[ADDR_W-1:IDX_W+2], addr_i_2[1:0]};

    // Grant decision; prio_q = 0 favours core 1, 1 favours core 2. Nothing is granted in reset.
    always_comb begin
        gnt_1_s     = 1'b0;
        gnt_2_s     = 1'b0;
        contested_s = 1'b0;
        if (!rst_n) begin
            gnt_1_s = 1'b0;
            gnt_2_s = 1'b0;
        end else if (req_1_s && req_2_s) begin
            contested_s = 1'b1;
            gnt_1_s     = ~prio_q;
            gnt_2_s     = prio_q;
        end else begin
            gnt_1_s = req_1_s;
            gnt_2_s = req_2_s;
        end
    end

    // Round-robin pointer moves to the loser only on contested cycles.
    always_comb begin
        prio_d = prio_q;
        if (contested_s) begin
            prio_d = gnt_1_s;
        end else begin
            prio_d = prio_q;
        end
    end

    // Single array port: select the granted core's access; a store wins over a load when both are set.
    always_comb begin
        rd_1_s    = gnt_1_s & MemRead_i_1 & ~MemWrite_i_1;
        rd_2_s    = gnt_2_s & MemRead_i_2 & ~MemWrite_i_2;
        wr_en_s   = (gnt_1_s & MemWrite_i_1) | (gnt_2_s & MemWrite_i_2);
        wr_idx_s  = gnt_2_s ? idx_2_s  : idx_1_s;
        wr_data_s = gnt_2_s ? data_i_2 : data_i_1;
    end

    // Next-state of the word array.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = (wr_en_s && (wr_idx_s == IDX_W'(i))) ? wr_data_s : mem_q[i];
        end
    end

    // Read data registers hold their value between loads; valid pulses for one cycle.
    always_comb begin
        data_o_1_d   = rd_1_s ? mem_q[idx_1_s] : data_o_1_q;
        data_o_2_d   = rd_2_s ? mem_q[idx_2_s] : data_o_2_q;
        rvalid_o_1_d = rd_1_s;
        rvalid_o_2_d = rd_2_s;
    end

    // State registers: priority, array and read ports.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            prio_q       <= 1'b0;
            data_o_1_q   <= {DATA_W{1'b0}};
            data_o_2_q   <= {DATA_W{1'b0}};
            rvalid_o_1_q <= 1'b0;
            rvalid_o_2_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            prio_q       <= prio_d;
            data_o_1_q   <= data_o_1_d;
            data_o_2_q   <= data_o_2_d;
            rvalid_o_1_q <= rvalid_o_1_d;
            rvalid_o_2_q <= rvalid_o_2_d;
            mem_q        <= mem_d;
        end
    end

    assign data_o_1   = data_o_1_q;
    assign data_o_2   = data_o_2_q;
    assign rvalid_o_1 = rvalid_o_1_q;
    assign rvalid_o_2 = rvalid_o_2_q;
    assign stall_o_1  = req_1_s & ~gnt_1_s & rst_n;
    assign stall_o_2  = req_2_s & ~gnt_2_s & rst_n;

`ifdef SHARED_DMEM_STATS_EN
    logic [15:0] acc_cnt_1_q;
    logic [15:0] acc_cnt_1_d;
    logic [15:0] acc_cnt_2_q;
    logic [15:0] acc_cnt_2_d;
    logic [15:0] conflict_cnt_q;
    logic [15:0] conflict_cnt_d;

    // Counter next-state.
    always_comb begin
        acc_cnt_1_d    = sat_inc(acc_cnt_1_q, gnt_1_s);
        acc_cnt_2_d    = sat_inc(acc_cnt_2_q, gnt_2_s);
        conflict_cnt_d = sat_inc(conflict_cnt_q, contested_s);
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_1_q    <= 16'd0;
            acc_cnt_2_q    <= 16'd0;
            conflict_cnt_q <= 16'd0;
        end else begin
            acc_cnt_1_q    <= acc_cnt_1_d;
            acc_cnt_2_q    <= acc_cnt_2_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign acc_cnt_o_1    = acc_cnt_1_q;
    assign acc_cnt_o_2    = acc_cnt_2_q;
    assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_shared_dmem_arbiter.sv
// Scoreboard bench for shared_dmem_arbiter: reference model of memory and round-robin priority,
// expected read data queued per core and consumed by an independent monitor.
module tb_shared_dmem_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 32;

    logic          clk_i = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] addr_i_1 = '0, addr_i_2 = '0;
    logic [DW-1:0] data_i_1 = '0, data_i_2 = '0;
    logic          MemRead_i_1 = 1'b0, MemWrite_i_1 = 1'b0;
    logic          MemRead_i_2 = 1'b0, MemWrite_i_2 = 1'b0;
    logic [DW-1:0] data_o_1, data_o_2;
    logic          rvalid_o_1, rvalid_o_2, stall_o_1, stall_o_2;

    shared_dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .addr_i_1(addr_i_1), .data_i_1(data_i_1), .MemRead_i_1(MemRead_i_1), .MemWrite_i_1(MemWrite_i_1),
        .data_o_1(data_o_1), .rvalid_o_1(rvalid_o_1), .stall_o_1(stall_o_1),
        .addr_i_2(addr_i_2), .data_i_2(data_i_2), .MemRead_i_2(MemRead_i_2), .MemWrite_i_2(MemWrite_i_2),
        .data_o_2(data_o_2), .rvalid_o_2(rvalid_o_2), .stall_o_2(stall_o_2)
    );

    always #5 clk_i = ~clk_i;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] mmem [DEPTH];
    int            prio_core = 1;
    logic [DW-1:0] exp_q1 [$];
    logic [DW-1:0] exp_q2 [$];
    logic [DW-1:0] last1 = '0;
    logic [DW-1:0] last2 = '0;
    bit            st1 = 1'b0;
    bit            st2 = 1'b0;

    function automatic int widx(input logic [AW-1:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one serviced request per cycle, contested winner is prio_core, loser becomes prio.
    task automatic model_cycle();
        bit q1, q2;
        int g;
        q1 = MemRead_i_1 | MemWrite_i_1;
        q2 = MemRead_i_2 | MemWrite_i_2;
        g  = 0;
        if (q1 && q2) begin
            g = prio_core;
            prio_core = (g == 1) ? 2 : 1;
        end else if (q1) g = 1;
        else if (q2) g = 2;
        st1 = q1 && (g != 1);
        st2 = q2 && (g != 2);
        check("stall_1", 32'(stall_o_1), 32'(st1));
        check("stall_2", 32'(stall_o_2), 32'(st2));
        if (g == 1) begin
            if (MemWrite_i_1) mmem[widx(addr_i_1)] = data_i_1;
            else exp_q1.push_back(mmem[widx(addr_i_1)]);
        end else if (g == 2) begin
            if (MemWrite_i_2) mmem[widx(addr_i_2)] = data_i_2;
            else exp_q2.push_back(mmem[widx(addr_i_2)]);
        end
    endtask

    task automatic step(input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic r2, input logic w2, input logic [AW-1:0] a2, input logic [DW-1:0] d2);
        @(negedge clk_i);
        MemRead_i_1 = r1; MemWrite_i_1 = w1; addr_i_1 = a1; data_i_1 = d1;
        MemRead_i_2 = r2; MemWrite_i_2 = w2; addr_i_2 = a2; data_i_2 = d2;
        #1;
        model_cycle();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Asserts reset immediately, checks the asynchronous clear, then releases on a later falling edge with inputs idle.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
        prio_core = 1;
        exp_q1.delete();
        exp_q2.delete();
        last1 = '0; last2 = '0; st1 = 1'b0; st2 = 1'b0;
        check("rst_rvalid_1", 32'(rvalid_o_1), 32'd0);
        check("rst_rvalid_2", 32'(rvalid_o_2), 32'd0);
        check("rst_data_1", data_o_1, 32'd0);
        check("rst_data_2", data_o_2, 32'd0);
        check("rst_stall_1", 32'(stall_o_1), 32'd0);
        check("rst_stall_2", 32'(stall_o_2), 32'd0);
        repeat (2) @(negedge clk_i);
        MemRead_i_1 = 1'b0; MemWrite_i_1 = 1'b0; MemRead_i_2 = 1'b0; MemWrite_i_2 = 1'b0;
        rst_n = 1'b1;
    endtask

    // Random request for one core; a stalled core usually holds its request, occasionally withdraws it.
    task automatic gen(input bit stalled, inout logic r, inout logic w, inout logic [AW-1:0] a, inout logic [DW-1:0] d);
        int kind;
        if (stalled && ($urandom_range(7) != 0)) begin
            r = r;
        end else if ($urandom_range(9) < 7) begin
            kind = $urandom_range(2);
            r = (kind != 1);
            w = (kind != 0);
            a = ($urandom_range(3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 127));
            d = 32'($urandom);
        end else begin
            r = 1'b0;
            w = 1'b0;
        end
    endtask

    // Monitor: consumes expected read data whenever a valid strobe appears, else checks the hold value.
    initial begin
        forever begin
            @(posedge clk_i);
            #2;
            if (rvalid_o_1) begin
                if (exp_q1.size() == 0) check("unexpected_rvalid_1", 32'd1, 32'd0);
                else begin
                    last1 = exp_q1.pop_front();
                    check("rdata_1", data_o_1, last1);
                end
            end else check("hold_1", data_o_1, last1);
            if (rvalid_o_2) begin
                if (exp_q2.size() == 0) check("unexpected_rvalid_2", 32'd1, 32'd0);
                else begin
                    last2 = exp_q2.pop_front();
                    check("rdata_2", data_o_2, last2);
                end
            end else check("hold_2", data_o_2, last2);
            check("missing_rvalid_1", 32'(exp_q1.size()), 32'd0);
            check("missing_rvalid_2", 32'(exp_q2.size()), 32'd0);
        end
    end

    initial begin
        logic          tr1, tw1, tr2, tw2;
        logic [AW-1:0] ta1, ta2;
        logic [DW-1:0] td1, td2;
        tr1 = 1'b0; tw1 = 1'b0; tr2 = 1'b0; tw2 = 1'b0;
        ta1 = '0; ta2 = '0; td1 = '0; td2 = '0;

        do_reset();
        repeat (3) idle();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        end

        // Store then load on core 1, uncontested.
        step(1'b0, 1'b1, 32'h8, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();

        // Contested stores to the same word; core 2 holds until granted, then prio checked via contested loads.
        step(1'b0, 1'b1, 32'h4, 32'h5, 1'b0, 1'b1, 32'h4, 32'h7);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h4, 32'h7);
        step(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);

        // Continuous contested loads to different words: alternating grants.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
        idle();

        // Contested store vs load to one word: stalled load sees the new value.
        step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h10, 32'hCAFE);
        step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h10, 32'hCAFE);
        step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Aliasing: 0x84 maps to word 1; read/write both set is a store.
        step(1'b1, 1'b1, 32'h84, 32'hA5A5_0001, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
        step(1'b1, 1'b0, 32'hFFFF_FF87, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();

        // Reset while core 2 is stalled: nothing performed, memory cleared, stale request not replayed.
        step(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b1, 32'h4, 32'h99);
        check("pre_reset_stall_2", 32'(stall_o_2), 32'd1);
        do_reset();
        step(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
        step(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);
        idle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            gen(st1, tr1, tw1, ta1, td1);
            gen(st2, tr2, tw2, ta2, td2);
            step(tr1, tw1, ta1, td1, tr2, tw2, ta2, td2);
        end
        repeat (3) idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
